// File: rtl/lector_destinos_if.sv
// Bus bundle for the destination drain engine: the D0/D1 FIFO pop side and
// the tagged valid/ready output stream.
interface lector_destinos_if #(
  parameter int BITNUMBER = 6
);
  // FIFO side
  logic                 D0_can_pop;
  logic                 D1_can_pop;
  logic [BITNUMBER-1:0] D0_data_out;
  logic [BITNUMBER-1:0] D1_data_out;
  logic                 pop_D0;
  logic                 pop_D1;
  // Output stream side
  logic [BITNUMBER-1:0] data_out;
  logic                 dest_out;
  logic                 valid_out;
  logic                 ready_in;

  // Drain engine view
  modport master (
    input  D0_can_pop, D1_can_pop, D0_data_out, D1_data_out, ready_in,
    output pop_D0, pop_D1, data_out, dest_out, valid_out
  );

  // FIFOs plus downstream consumer view
  modport slave (
    output D0_can_pop, D1_can_pop, D0_data_out, D1_data_out, ready_in,
    input  pop_D0, pop_D1, data_out, dest_out, valid_out
  );
endinterface

// File: rtl/lector_destinos.sv
// Drain engine: round-robin pops the D0/D1 output FIFOs, captures each popped
// word and presents it on a valid/ready stream tagged with its source, while
// keeping saturating per-destination delivered-word counters.
module lector_destinos #(
  parameter int BITNUMBER = 6,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  lector_destinos_if.master bus,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              idle
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_CAPTURE = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 pop0_q, pop0_d;
  logic                 pop1_q, pop1_d;
  logic [BITNUMBER-1:0] data_q, data_d;
  logic                 dest_q, dest_d;
  logic                 valid_q, valid_d;
  logic                 rr_q, rr_d;     // destination preferred when both pending
  logic [CNT_W-1:0]     cnt0_q, cnt0_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d;
  logic                 idle_q, idle_d;
  logic                 sel;            // destination chosen in IDLE
  logic                 handshake;

  assign handshake = valid_q && bus.ready_in;

  // Next-state and registered-output computation for the drain FSM.
  always_comb begin
    state_d = state_q;
    pop0_d  = 1'b0;
    pop1_d  = 1'b0;
    data_d  = data_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only here are the can_pop flags looked at; a single pending FIFO
        // wins outright, otherwise the pointer breaks the tie.
        if (bus.D0_can_pop || bus.D1_can_pop) begin
          if (bus.D0_can_pop && bus.D1_can_pop) begin
            sel = rr_q;
          end else begin
            sel = bus.D1_can_pop;
          end
          dest_d  = sel;
          pop0_d  = ~sel;
          pop1_d  = sel;
          state_d = S_POP;
        end
      end

      S_POP: begin
        // The pop strobe is high during this state; FIFO data follows next cycle.
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        data_d  = dest_q ? bus.D1_data_out : bus.D0_data_out;
        valid_d = 1'b1;
        rr_d    = ~dest_q;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (dest_q) begin
            if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
          end else begin
            if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // init clears status and pointer but lets the transaction in flight finish.
    if (init) begin
      cnt0_d = '0;
      cnt1_d = '0;
      rr_d   = 1'b0;
    end

    idle_d = (state_d == S_IDLE);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      data_q  <= '0;
      dest_q  <= 1'b0;
      valid_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pop0_q  <= pop0_d;
      pop1_q  <= pop1_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.pop_D0    = pop0_q;
  assign bus.pop_D1    = pop1_q;
  assign bus.data_out  = data_q;
  assign bus.dest_out  = dest_q;
  assign bus.valid_out = valid_q;
  assign cnt_D0        = cnt0_q;
  assign cnt_D1        = cnt1_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_lector_destinos.sv
// Bench for the destination drain engine: FIFO models feed D0/D1, a
// round-robin model predicts the delivered word order into a scoreboard, and
// a monitor checks every output word, the pop strobes and the counters.
module tb_lector_destinos;

  localparam int BN    = 6;
  localparam int CW    = 5;
  localparam int CSAT  = (1 << CW) - 1;

  typedef struct {
    bit            dest;
    logic [BN-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [CW-1:0] cnt_D0;
  logic [CW-1:0] cnt_D1;
  logic          idle;

  lector_destinos_if #(.BITNUMBER(BN)) bus ();

  lector_destinos #(.BITNUMBER(BN), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .init   (init),
    .bus    (bus),
    .cnt_D0 (cnt_D0),
    .cnt_D1 (cnt_D1),
    .idle   (idle)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  logic [BN-1:0] q0[$];
  logic [BN-1:0] q1[$];
  logic [BN-1:0] a0[$];
  logic [BN-1:0] a1[$];
  bit            rr_m = 1'b0;     // model: destination preferred on a tie
  int            cnt_m0 = 0;
  int            cnt_m1 = 0;
  int            ready_pct = 100;
  bit            ready_manual = 1'b0;
  bit            ready_force = 1'b0;
  bit            mon_en = 1'b0;

  // monitor history
  bit            prev_pop = 1'b0;
  bit            prev_valid = 1'b0;
  bit            prev_stall = 1'b0;
  logic [BN-1:0] hold_data = '0;
  bit            hold_dest = 1'b0;
  int            pop_cyc = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random with a given probability, or forced.
  initial begin
    bus.ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_manual) bus.ready_in = ready_force;
      else              bus.ready_in = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // FIFO models: read data appears the cycle after a pop.
  initial begin
    bus.D0_can_pop  = 1'b0;
    bus.D1_can_pop  = 1'b0;
    bus.D0_data_out = '0;
    bus.D1_data_out = '0;
    forever begin
      @(negedge clk);
      if (bus.pop_D0) begin
        check(q0.size() > 0, "pop_D0_nonempty", q0.size(), 1);
        if (q0.size() > 0) bus.D0_data_out = q0.pop_front();
      end
      if (bus.pop_D1) begin
        check(q1.size() > 0, "pop_D1_nonempty", q1.size(), 1);
        if (q1.size() > 0) bus.D1_data_out = q1.pop_front();
      end
      bus.D0_can_pop = (q0.size() > 0);
      bus.D1_can_pop = (q1.size() > 0);
    end
  end

  // Monitor: pop strobe rules, send stability, latency, scoreboard, counters.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_pop = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
        cnt_m0 = 0; cnt_m1 = 0;
      end else begin
        if (bus.pop_D0 || bus.pop_D1) begin
          check(!(bus.pop_D0 && bus.pop_D1) && !bus.valid_out, "pop_exclusive",
                int'({bus.pop_D0, bus.pop_D1, bus.valid_out}), bus.pop_D0 ? 4 : 2);
          check(!prev_pop, "pop_width", int'(prev_pop), 0);
          pop_cyc = cyc;
        end
        if (prev_stall)
          check(bus.valid_out && bus.data_out == hold_data && bus.dest_out == hold_dest,
                "send_stable", int'(bus.data_out), int'(hold_data));
        if (bus.valid_out && !prev_valid)
          check(cyc - pop_cyc == 2, "pop_to_valid", cyc - pop_cyc, 2);
        if (bus.valid_out && bus.ready_in) begin
          check(cnt_D0 == cnt_m0, "cnt_D0_before_hs", int'(cnt_D0), cnt_m0);
          check(cnt_D1 == cnt_m1, "cnt_D1_before_hs", int'(cnt_D1), cnt_m1);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_word", int'(bus.data_out), -1);
          end else begin
            e = exp_q.pop_front();
            check(bus.dest_out == e.dest, "dest_out", int'(bus.dest_out), int'(e.dest));
            check(bus.data_out == e.data, "data_out", int'(bus.data_out), int'(e.data));
            if (e.dest) cnt_m1 = (cnt_m1 < CSAT) ? cnt_m1 + 1 : CSAT;
            else        cnt_m0 = (cnt_m0 < CSAT) ? cnt_m0 + 1 : CSAT;
          end
        end
        if (init) begin
          cnt_m0 = 0;
          cnt_m1 = 0;
        end
        prev_pop   = bus.pop_D0 || bus.pop_D1;
        prev_valid = bus.valid_out;
        prev_stall = bus.valid_out && !bus.ready_in;
        hold_data  = bus.data_out;
        hold_dest  = bus.dest_out;
      end
    end
  end

  // Predict the delivery order of a batch from the arbitration rule, then
  // hand the words to the FIFO models (both become visible together).
  task automatic do_load();
    int i0 = 0;
    int i1 = 0;
    bit p;
    exp_t e;
    while (i0 < a0.size() || i1 < a1.size()) begin
      if (i0 < a0.size() && i1 < a1.size()) p = rr_m;
      else                                  p = (i0 < a0.size()) ? 1'b0 : 1'b1;
      e.dest = p;
      if (p) begin e.data = a1[i1]; i1++; end
      else   begin e.data = a0[i0]; i0++; end
      exp_q.push_back(e);
      rr_m = ~p;
    end
    @(posedge clk);
    #2;
    q0 = a0;
    q1 = a1;
    a0.delete();
    a1.delete();
  endtask

  task automatic fill_random(input int n0, input int n1);
    for (int i = 0; i < n0; i++) a0.push_back(BN'($urandom));
    for (int i = 0; i < n1; i++) a1.push_back(BN'($urandom));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.valid_out || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      check(1'b0, "drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.valid_out && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) check(1'b0, "valid_timeout", int'(bus.valid_out), 1);
  endtask

  task automatic pulse_init();
    @(posedge clk);
    #2 init = 1'b1;
    @(posedge clk);
    #2 init = 1'b0;
    rr_m = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check(bus.valid_out == 1'b0 && bus.pop_D0 == 1'b0 && bus.pop_D1 == 1'b0, "reset_strobes",
          int'({bus.valid_out, bus.pop_D0, bus.pop_D1}), 0);
    check(bus.data_out == '0 && bus.dest_out == 1'b0, "reset_data",
          int'(bus.data_out), 0);
    check(cnt_D0 == '0 && cnt_D1 == '0, "reset_counters", int'(cnt_D0) + int'(cnt_D1), 0);
    check(idle == 1'b1, "reset_idle", int'(idle), 1);
    reset = 1'b1;
    mon_en = 1'b1;

    // Single D0 word
    a0.push_back(6'b000001);
    do_load();
    drain(50);
    check(cnt_D0 == 5'd1, "single_cnt_D0", int'(cnt_D0), 1);

    // Both pending for four words: strict alternation from D0
    pulse_init();
    fill_random(2, 2);
    do_load();
    drain(100);
    check(cnt_D0 == 5'd2, "alt_cnt_D0", int'(cnt_D0), 2);
    check(cnt_D1 == 5'd2, "alt_cnt_D1", int'(cnt_D1), 2);

    // Stall in SEND for 5 cycles with a D1 word
    ready_manual = 1'b1;
    ready_force  = 1'b0;
    a1.push_back(6'b110101);
    do_load();
    wait_valid(20);
    repeat (5) @(posedge clk);
    #2;
    ready_force = 1'b1;
    drain(50);
    ready_manual = 1'b0;
    check(cnt_D1 == 5'd3, "stall_cnt_D1", int'(cnt_D1), 3);

    // Random batches with random backpressure
    for (int ph = 0; ph < 12; ph++) begin
      ready_pct = $urandom_range(30, 100);
      fill_random($urandom_range(0, 4), $urandom_range(0, 4));
      do_load();
      drain(400);
    end
    ready_pct = 100;

    // Counter saturation
    pulse_init();
    fill_random(33, 0);
    do_load();
    drain(400);
    check(cnt_D0 == 5'd31, "sat_cnt_D0", int'(cnt_D0), 31);
    check(cnt_D1 == 5'd0, "sat_cnt_D1", int'(cnt_D1), 0);

    // init coinciding with a handshake
    pulse_init();
    fill_random(3, 0);
    do_load();
    drain(100);
    check(cnt_D0 == 5'd3, "pre_init_cnt_D0", int'(cnt_D0), 3);
    ready_manual = 1'b1;
    ready_force  = 1'b0;
    fill_random(1, 0);
    do_load();
    wait_valid(20);
    ready_force = 1'b1;
    @(posedge clk);
    #2 init = 1'b1;
    @(posedge clk);
    #2 init = 1'b0;
    ready_manual = 1'b0;
    rr_m = 1'b0;
    check(cnt_D0 == 5'd0, "init_hs_cnt_D0", int'(cnt_D0), 0);
    check(idle == 1'b1, "init_hs_idle", int'(idle), 1);
    fill_random(1, 1);
    do_load();
    drain(100);

    // Asynchronous reset during SEND
    ready_manual = 1'b1;
    ready_force  = 1'b0;
    fill_random(0, 1);
    do_load();
    wait_valid(20);
    @(posedge clk);
    #3;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check(bus.valid_out == 1'b0 && bus.pop_D0 == 1'b0 && bus.pop_D1 == 1'b0, "async_strobes",
          int'({bus.valid_out, bus.pop_D0, bus.pop_D1}), 0);
    check(bus.data_out == '0 && bus.dest_out == 1'b0, "async_data", int'(bus.data_out), 0);
    check(cnt_D0 == '0 && cnt_D1 == '0, "async_counters", int'(cnt_D0) + int'(cnt_D1), 0);
    check(idle == 1'b1, "async_idle", int'(idle), 1);
    exp_q.delete();
    q0.delete();
    q1.delete();
    rr_m = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
    ready_manual = 1'b0;

    // Recovery after reset: pointer back at D0
    fill_random(1, 1);
    do_load();
    drain(100);
    check(cnt_D0 == 5'd1 && cnt_D1 == 5'd1, "recover_counts",
          int'(cnt_D0) * 100 + int'(cnt_D1), 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
